// File: rtl/alu_reservation_station_if.sv
// Decoder, CDB and ALU-issue signals of the ALU reservation station.
// The master side is the environment (decoder, CDB, ALU), the slave side is the station.
interface alu_reservation_station_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
);
    localparam int ALU_DATA_W = (TAG_W - 1) + 2 * (TAG_W + DATA_W) + OP_W;

    logic                  aluEnable;
    logic [ALU_DATA_W-1:0] aluData;
    logic                  rsFull;
    logic                  cdbValid;
    logic [TAG_W-1:0]      cdbTag;
    logic [DATA_W-1:0]     cdbData;
    logic                  flush;
    logic                  issueValid;
    logic                  issueReady;
    logic [OP_W-1:0]       issueOp;
    logic [DATA_W-1:0]     issueA;
    logic [DATA_W-1:0]     issueB;
    logic [TAG_W-2:0]      issueDest;

    modport master (
        output aluEnable, aluData, cdbValid, cdbTag, cdbData, flush, issueReady,
        input  rsFull, issueValid, issueOp, issueA, issueB, issueDest
    );

    modport slave (
        input  aluEnable, aluData, cdbValid, cdbTag, cdbData, flush, issueReady,
        output rsFull, issueValid, issueOp, issueA, issueB, issueDest
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds decoded ALU ops until both operands are
// ready (tag MSB set), wakes operands from the CDB, issues one op per cycle
// to the ALU through a registered valid/ready slot.
module alu_reservation_station #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int RS_SIZE = 8
) (
    input logic clk,
    input logic rst,
    alu_reservation_station_if.slave rs_if
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int D1_LO = OP_W;
    localparam int T1_LO = D1_LO + DATA_W;
    localparam int D2_LO = T1_LO + TAG_W;
    localparam int T2_LO = D2_LO + DATA_W;
    localparam int DS_LO = T2_LO + TAG_W;
    localparam logic [TAG_W-1:0] TAG_RDY = {1'b1, {(TAG_W-1){1'b0}}};

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [RS_SIZE], op_d    [RS_SIZE];
    logic [TAG_W-2:0]   dest_q  [RS_SIZE], dest_d  [RS_SIZE];
    logic [TAG_W-1:0]   tag1_q  [RS_SIZE], tag1_d  [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q  [RS_SIZE], tag2_d  [RS_SIZE];
    logic [DATA_W-1:0]  data1_q [RS_SIZE], data1_d [RS_SIZE];
    logic [DATA_W-1:0]  data2_q [RS_SIZE], data2_d [RS_SIZE];

    logic              issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d;
    logic [DATA_W-1:0] issue_b_q, issue_b_d;
    logic [TAG_W-2:0]  issue_dest_q, issue_dest_d;

    logic              rs_full;
    logic              sel_found, free_found, can_issue, alloc;
    logic [IDX_W-1:0]  sel_idx, free_idx;
    logic [TAG_W-1:0]  in_tag1, in_tag2;
    logic              in_hit1, in_hit2;

    assign rs_full = &valid_q;
    assign in_tag1 = rs_if.aluData[T1_LO +: TAG_W];
    assign in_tag2 = rs_if.aluData[T2_LO +: TAG_W];
    assign in_hit1 = rs_if.cdbValid && !in_tag1[TAG_W-1] && (in_tag1 == rs_if.cdbTag);
    assign in_hit2 = rs_if.cdbValid && !in_tag2[TAG_W-1] && (in_tag2 == rs_if.cdbTag);

    // Next-state: wakeup, selection/issue, allocation with CDB bypass, flush override.
    always_comb begin
        valid_d       = valid_q;
        op_d          = op_q;
        dest_d        = dest_q;
        tag1_d        = tag1_q;
        tag2_d        = tag2_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_dest_d  = issue_dest_q;
        sel_found     = 1'b0;
        sel_idx       = '0;
        free_found    = 1'b0;
        free_idx      = '0;

        // Selection and free-slot search both look at registered state only,
        // so an op written this cycle can never be issued this cycle.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!sel_found && valid_q[i] && tag1_q[i][TAG_W-1] && tag2_q[i][TAG_W-1]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && rs_if.cdbValid && !tag1_q[i][TAG_W-1] && (tag1_q[i] == rs_if.cdbTag)) begin
                tag1_d[i]  = tag1_q[i] | TAG_RDY;
                data1_d[i] = rs_if.cdbData;
            end
            if (valid_q[i] && rs_if.cdbValid && !tag2_q[i][TAG_W-1] && (tag2_q[i] == rs_if.cdbTag)) begin
                tag2_d[i]  = tag2_q[i] | TAG_RDY;
                data2_d[i] = rs_if.cdbData;
            end
        end

        can_issue = !issue_valid_q || rs_if.issueReady;
        if (can_issue) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_op_d       = op_q[sel_idx];
                issue_a_d        = data1_q[sel_idx];
                issue_b_d        = data2_q[sel_idx];
                issue_dest_d     = dest_q[sel_idx];
                valid_d[sel_idx] = 1'b0;
            end
        end

        alloc = rs_if.aluEnable && !rs_full && !rs_if.flush;
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = rs_if.aluData[OP_W-1:0];
            dest_d[free_idx]  = rs_if.aluData[DS_LO +: (TAG_W-1)];
            tag1_d[free_idx]  = in_hit1 ? (in_tag1 | TAG_RDY) : in_tag1;
            data1_d[free_idx] = in_hit1 ? rs_if.cdbData : rs_if.aluData[D1_LO +: DATA_W];
            tag2_d[free_idx]  = in_hit2 ? (in_tag2 | TAG_RDY) : in_tag2;
            data2_d[free_idx] = in_hit2 ? rs_if.cdbData : rs_if.aluData[D2_LO +: DATA_W];
        end

        if (rs_if.flush) begin
            valid_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q       <= '0;
            op_q          <= '{default: '0};
            dest_q        <= '{default: '0};
            tag1_q        <= '{default: '0};
            tag2_q        <= '{default: '0};
            data1_q       <= '{default: '0};
            data2_q       <= '{default: '0};
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_dest_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            op_q          <= op_d;
            dest_q        <= dest_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_dest_q  <= issue_dest_d;
        end
    end

    assign rs_if.rsFull     = rs_full;
    assign rs_if.issueValid = issue_valid_q;
    assign rs_if.issueOp    = issue_op_q;
    assign rs_if.issueA     = issue_a_q;
    assign rs_if.issueB     = issue_b_q;
    assign rs_if.issueDest  = issue_dest_q;
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Downstream neighbour of the instruction decoder: buffers decoded ALU-class ops (RI, RR, LUI, JAL, JALR) until both operands are ready, then issues one op per cycle to the ALU.
- Snoops a single common data bus (CDB) to wake up pending operands.
- Back-pressures the decoder with rsFull.
- Cleared on branch flush.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, tag width; MSB set (tag[TAG_W-1]==1) means "free/value ready"; low TAG_W-1 bits are the ROB index.
- OP_W, 6, ALU opcode width.
- RS_SIZE, 8, number of entries.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- aluEnable  in  1  decoder allocation request.
- aluData  in  (TAG_W-1)+2*(TAG_W+DATA_W)+OP_W  packed {dest[TAG_W-2:0], tag2, data2, tag1, data1, op}, MSB to LSB; 81 bits at defaults.
- rsFull  out  1  all entries valid; decoder must hold aluEnable low.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  producing ROB tag (MSB 0).
- cdbData  in  DATA_W  broadcast value.
- flush  in  1  mispredict flush.
- issueValid  out  1  issue slot holds an op.
- issueReady  in  1  ALU accepts this cycle.
- issueOp  out  OP_W  opcode.
- issueA  out  DATA_W  operand 1 value.
- issueB  out  DATA_W  operand 2 value.
- issueDest  out  TAG_W-1  destination ROB index.

Behaviour:
- Reset: posedge with rst==0 clears all entry valid bits, issueValid=0, issueOp/issueA/issueB/issueDest=0. rsFull=0 follows from the cleared valid bits.
- Entry state: valid, op, dest, tag1/data1, tag2/data2. An operand is ready iff its tag MSB==1.
- rsFull is combinational: AND of all entry valid bits.
- Allocation: aluEnable && !rsFull && !flush writes the lowest-index invalid entry at the posedge.
- Allocation while rsFull=1 is ignored (no entry written, no state change). The bench flags it as a protocol error.
- Allocation bypass: if cdbValid and an incoming tagN equals cdbTag (tagN MSB 0), the entry stores cdbData for that operand and marks it ready.
- Wakeup: every posedge, each valid entry whose operand tag (MSB 0) equals cdbTag with cdbValid=1 latches cdbData and sets the tag to ready. Both operands may wake in the same cycle.
- Selection: the lowest-index valid entry with both operands ready, evaluated on current registered state. Entries written or woken at edge N are selectable from edge N+1, giving a minimum one-cycle allocate-to-issue latency.
- Issue handshake: issueValid && !issueReady holds all issue outputs stable and selects nothing.
- When !issueValid or issueReady, at the posedge:
  - if a selectable entry exists, it is copied to the issue registers, issueValid=1, and the entry's valid bit is cleared;
  - otherwise issueValid=0.
- Back-to-back issue at 1 op/cycle is sustained while issueReady stays high.
- Slot reuse: a slot freed by issue at edge N can be allocated at edge N+1. rsFull reflects state after the edge.
- Flush: flush=1 at a posedge clears all valid bits and issueValid. Allocation, wakeup and issue in that cycle are discarded. Flush has priority over everything except reset.
- Simultaneous allocation and issue in one cycle are independent. An op allocated in that cycle is never issued in the same cycle.
- No arithmetic is performed here. Operand data is passed verbatim.

Test Plan:
- Reset, then RR op allocated with both operands ready (tag 4'b1000, data1=5, data2=7, dest=3) and issueReady=1 → next cycle no issue; the following edge gives issueValid=1, issueA=5, issueB=7, issueDest=3.
- Op with tag1=4'b0010 pending, then cdbValid/cdbTag=2/cdbData=0xDEAD two cycles later → issue one cycle after the broadcast with issueA=0xDEAD. A second entry waiting on tag 5 is not woken.
- Allocation in the same cycle as cdbTag=2 broadcast, with incoming tag2=2 → entry captured ready with data2=cdbData and issued one cycle later.
- Fill 8 entries, all waiting on tag 1, with issueReady=0 → rsFull=1 and a 9th aluEnable is ignored. Broadcast tag 1 with issueReady=1 → ops issue from index 0..7 on consecutive cycles; rsFull drops after the first issue.
- issueValid=1 with issueReady low for 3 cycles → outputs remain stable and no entry is freed; the same op is accepted when issueReady rises.
- Flush asserted with 4 entries valid, issueValid=1 and a concurrent aluEnable → next cycle issueValid=0, rsFull=0, nothing issues afterwards. Mid-operation rst=0 gives the same cleared state.
